// File: rtl/prirv32_mdu_pkg.sv
// Shared multiply/divide unit definitions: operand width, RV32M multiply op
// encodings, controller states and the sign-handling helpers.
package prirv32_mdu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } mul_state_e;

  // Magnitude of a possibly negative operand; 0x80000000 maps onto itself.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
    if (neg) begin
      return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  function automatic logic [2*XLEN-1:0] negate64(input logic [2*XLEN-1:0] p);
    return (~p) + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [XLEN-1:0] select_half(input logic [2*XLEN-1:0] p, input mul_op_e op);
    case (op)
      OP_MUL:  return p[XLEN-1:0];
      default: return p[2*XLEN-1:XLEN];
    endcase
  endfunction

endpackage

// File: rtl/ArrayMultiplier.sv
// Combinational 32x32 unsigned array multiplier: sum of shifted partial products.
module ArrayMultiplier (
  output logic [63:0] product,
  input  logic [31:0] a,
  input  logic [31:0] x
);

  // Accumulate one partial-product row per multiplier bit.
  always_comb begin
    product = 64'd0;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) begin
        product = product + ({32'd0, a} << i);
      end else begin
        product = product;
      end
    end
  end

endmodule

// File: rtl/prirv32_mul_ctrl.sv
// RV32M multiply sequencer around a settling array multiplier.
// Optional PRIRV32_MUL_FUSE_EN adds a last-result cache for fused MULH/MUL pairs.
module prirv32_mul_ctrl
  import prirv32_mdu_pkg::*;
#(
  parameter int unsigned MUL_SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  mul_state_e        state_r;
  mul_op_e           op_r;
  logic [XLEN-1:0]   mag_a_r, mag_b_r;
  logic              neg_r;
  logic [3:0]        cnt_r;
  logic [XLEN-1:0]   result_r;
  logic              valid_r, busy_r;

  mul_op_e           req_op_s;
  logic              accept_s, sign_a_s, sign_b_s, done_entry_s;
  logic              hit_s;
  logic [XLEN-1:0]   hit_result_s;
  logic [2*XLEN-1:0] product_s, signed_prod_s;

  ArrayMultiplier u_array_mul (
    .product (product_s),
    .a       (mag_a_r),
    .x       (mag_b_r)
  );

  assign in_ready   = (state_r == IDLE) && !flush;
  assign out_valid  = valid_r;
  assign out_result = result_r;
  assign busy       = busy_r;

  // Request decode: operand signedness, accept and product sign correction.
  always_comb begin
    req_op_s      = mul_op_e'(in_op);
    sign_a_s      = ((req_op_s == OP_MULH) || (req_op_s == OP_MULHSU)) && in_rs1[XLEN-1];
    sign_b_s      = (req_op_s == OP_MULH) && in_rs2[XLEN-1];
    accept_s      = in_valid && in_ready;
    done_entry_s  = (state_r == WAIT) && (cnt_r == 4'd0) && !flush && !rst;
    signed_prod_s = neg_r ? negate64(product_s) : product_s;
  end

`ifdef PRIRV32_MUL_FUSE_EN
  logic              c_valid_r;
  logic [XLEN-1:0]   c_rs1_r, c_rs2_r, rs1_r, rs2_r;
  mul_op_e           c_op_r;
  logic [2*XLEN-1:0] c_prod_r;

  // A low-half request can reuse any cached product of the same operands.
  always_comb begin
    hit_s        = c_valid_r && (in_rs1 == c_rs1_r) && (in_rs2 == c_rs2_r) &&
                   ((req_op_s == OP_MUL) || (req_op_s == c_op_r));
    hit_result_s = select_half(c_prod_r, req_op_s);
  end

  // Cache of the last computed operation; survives flush, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid_r <= 1'b0;
      c_rs1_r   <= {XLEN{1'b0}};
      c_rs2_r   <= {XLEN{1'b0}};
      c_op_r    <= OP_MUL;
      c_prod_r  <= {(2*XLEN){1'b0}};
      rs1_r     <= {XLEN{1'b0}};
      rs2_r     <= {XLEN{1'b0}};
    end else begin
      if (accept_s) begin
        rs1_r <= in_rs1;
        rs2_r <= in_rs2;
      end
      if (done_entry_s) begin
        c_valid_r <= 1'b1;
        c_rs1_r   <= rs1_r;
        c_rs2_r   <= rs2_r;
        c_op_r    <= op_r;
        c_prod_r  <= signed_prod_s;
      end
    end
  end
`else
  assign hit_s        = 1'b0;
  assign hit_result_s = {XLEN{1'b0}};
`endif

  // Controller FSM with registered result, valid and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      op_r     <= OP_MUL;
      mag_a_r  <= {XLEN{1'b0}};
      mag_b_r  <= {XLEN{1'b0}};
      neg_r    <= 1'b0;
      cnt_r    <= 4'd0;
      result_r <= {XLEN{1'b0}};
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else if (flush) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r   <= req_op_s;
            busy_r <= 1'b1;
            if (hit_s) begin
              result_r <= hit_result_s;
              valid_r  <= 1'b1;
              state_r  <= DONE;
            end else begin
              mag_a_r <= magnitude(in_rs1, sign_a_s);
              mag_b_r <= magnitude(in_rs2, sign_b_s);
              neg_r   <= sign_a_s ^ sign_b_s;
              cnt_r   <= 4'(MUL_SETTLE - 1);
              state_r <= WAIT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          // Operands stay frozen here so the array output has settled at count 0.
          if (cnt_r == 4'd0) begin
            result_r <= select_half(signed_prod_s, op_r);
            valid_r  <= 1'b1;
            state_r  <= DONE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prirv32_mul_ctrl.sv
// Scoreboard bench for prirv32_mul_ctrl: directed RV32M vectors, hold, flush and reset.
module tb_prirv32_mul_ctrl;
  import prirv32_mdu_pkg::*;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_rs1, in_rs2;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_result;

  prirv32_mul_ctrl #(.MUL_SETTLE(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [15] = '{
    '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000},
    '{2'b10, 32'h80000000, 32'h80000000, 32'hC0000000},
    '{2'b11, 32'h80000000, 32'h80000000, 32'h40000000},
    '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF},
    '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE},
    '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
    '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF},
    '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA},
    '{2'b11, 32'h00010000, 32'h00010000, 32'h00000001},
    '{2'b00, 32'h00010000, 32'h00010000, 32'h00000000},
    '{2'b01, 32'h00000007, 32'h00000009, 32'h00000000},
    '{2'b00, 32'h00000007, 32'h00000009, 32'h0000003F},
    '{2'b11, 32'h00000007, 32'h00000009, 32'h00000000}
  };

  int checks = 0;
  int failures = 0;
  bit seen = 1'b0;

  // Cache model: last non-hit operation accepted and expected to complete.
  bit          m_valid = 1'b0;
  logic [31:0] m_rs1, m_rs2;
  logic [1:0]  m_op;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s got=timeout exp=event", name);
  endtask

  // Monitor: latency on first valid cycle, result on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid got=1 exp=0 result=%h", out_result);
      end else begin
        if (!seen) begin
          chk("latency_cycle", 32'(cyc), 32'(sb[0].due));
          seen = 1'b1;
        end
        if (out_ready) begin
          chk("result", out_result, sb[0].res);
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input bit expect_out);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    in_valid = 1'b1;
    in_op = op;
    in_rs1 = a;
    in_rs2 = b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      bound_fail("accept_timeout");
    end else if (expect_out) begin
`ifdef PRIRV32_MUL_FUSE_EN
      hit = m_valid && (a == m_rs1) && (b == m_rs2) && ((op == 2'b00) || (op == m_op));
      if (!hit) begin
        m_valid = 1'b1;
        m_rs1 = a;
        m_rs2 = b;
        m_op = op;
      end
`endif
      sb.push_back('{res: res, due: cyc + (hit ? 1 : S + 1)});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) bound_fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) bound_fail("valid_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_rs1 = 32'd0; in_rs2 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, 1'b1);
    end
    drain();

    // Result held while the consumer stalls.
    out_ready = 1'b0;
    issue(2'b11, 32'h00010000, 32'h00010000, 32'h00000001, 1'b1);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", out_result, 32'h00000001);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("handshake_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_hs_busy", {31'd0, busy}, 32'd0);
    chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Flush in the first WAIT cycle; a flush held in IDLE still blocks accept.
    issue(2'b00, 32'd3, 32'd5, 32'd15, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_wait_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("flush_idle_in_ready", {31'd0, in_ready}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    for (int k = 0; k < S + 3; k++) begin
      @(negedge clk);
      chk("flush_no_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("flush_recovered_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Reset while a result waits in DONE.
    out_ready = 1'b0;
    issue(2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b1);
    wait_valid();
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    seen = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_done_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done_result", out_result, 32'd0);
    chk("rst_done_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // After reset nothing may be served from a cache.
    issue(2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prirv32_mul_ctrl.md
PRIRV32_MUL_CTRL -- requirements
Module: prirv32_mul_ctrl

Interface
REQ-001 SHALL have parameter MUL_SETTLE, default 2, meaning the number of cycles the array-multiplier operands are held stable before the product is captured (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request offered.
REQ-005 SHALL have port in_ready  output  1  controller accepts a request this cycle.
REQ-006 SHALL have port in_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (RV32M funct3[1:0]).
REQ-007 SHALL have port in_rs1  input  32  multiplicand.
REQ-008 SHALL have port in_rs2  input  32  multiplier.
REQ-009 SHALL have port flush  input  1  abandon any in-flight or undelivered operation.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port out_result  output  32  MUL: product[31:0]; others: product[63:32].
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, WAIT, DONE; in_ready = (state == IDLE) and not flush.
REQ-015 SHALL, on accept (in_valid and in_ready), register the magnitudes |rs1| and |rs2|, the op, and neg = sign_a xor sign_b, and enter WAIT with settle counter = MUL_SETTLE-1.
REQ-016 SHALL treat rs1 as signed for MULH and MULHSU, rs2 as signed for MULH only, and every other operand as unsigned (sign = 0).
REQ-017 SHALL form each magnitude as the two's complement of a negative signed operand; 0x80000000 SHALL yield magnitude 0x80000000 (unsigned 32-bit, no overflow).
REQ-018 SHALL feed the registered magnitudes to the 32x32 unsigned array multiplier and keep them unchanged while the state is WAIT.
REQ-019 SHALL, in WAIT, decrement the counter each cycle; in the cycle the counter is 0 it SHALL capture the 64-bit product, negate it (64-bit two's complement) when neg = 1, select the output half per REQ-012 into out_result, and enter DONE.
REQ-020 SHALL assert out_valid exactly in DONE, so the first out_valid cycle is accept cycle + MUL_SETTLE + 1.
REQ-021 SHALL hold out_result and out_valid stable in DONE until out_ready; on out_valid and out_ready it SHALL return to IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-022 SHALL, on flush, enter IDLE on the next cycle from any state, deassert out_valid, and discard the operation; flush takes priority over accept and completion.
REQ-023 SHALL ignore in_op, in_rs1 and in_rs2 while not in IDLE.

Reset
REQ-024 SHALL, on rst, enter IDLE with out_valid = 0, out_result = 0, busy = 0, counter = 0, all operand/product registers = 0, and the hit cache invalid; rst overrides flush and all handshakes.

Configuration
REQ-025 SHALL, with PRIRV32_MUL_FUSE_EN defined, keep a cache of the last completed operation: rs1, rs2, op and the sign-corrected 64-bit product, marked valid on entry to DONE.
REQ-026 SHALL, with PRIRV32_MUL_FUSE_EN defined, treat an accepted request as a hit when the cache is valid, rs1 and rs2 match, and either the new op is MUL or the new op equals the cached op; a hit SHALL go straight to DONE with out_valid in accept cycle + 1, taking the result from the cache.
REQ-027 SHALL, with PRIRV32_MUL_FUSE_EN defined, leave the cache unchanged on flush; only rst invalidates it.
REQ-028 SHALL, without PRIRV32_MUL_FUSE_EN, contain no cache registers, and every request SHALL take the REQ-020 latency.

Structure
REQ-029 SHALL take the XLEN = 32 constant, the op encodings and the state enumeration from shared package prirv32_mdu_pkg.
REQ-030 SHALL instantiate exactly one sub-module, the existing ArrayMultiplier (product, a, x), with all sequencing and sign logic in the controller.

Verification
REQ-031 SHALL cover: MUL_SETTLE=2, MULHU 0xFFFFFFFF x 0xFFFFFFFF accepted at cycle 0 -> out_valid at cycle 3, out_result 0xFFFFFFFE.
REQ-032 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULH 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF; MUL of the same pair -> 0xFFFFFFFE.
REQ-033 SHALL cover: MULHSU 0xFFFFFFFF (-1) x 0xFFFFFFFF (unsigned) -> 0xFFFFFFFF; MULHU of the same pair -> 0xFFFFFFFE.
REQ-034 SHALL cover: result held with out_ready=0 for 5 cycles -> out_valid and out_result stable, in_ready=0, busy=1; handshake cycle -> IDLE next cycle, in_ready=1.
REQ-035 SHALL cover: flush in the WAIT cycle after accept -> out_valid never asserts, IDLE next cycle; rst asserted in DONE -> all outputs 0 the next cycle.
REQ-036 SHALL cover: with PRIRV32_MUL_FUSE_EN defined, MULH 7 x 9 completes, then MUL 7 x 9 -> out_valid at accept + 1, out_result 63; then MULHU 7 x 9 -> full MUL_SETTLE + 1 latency.
